// File: rtl/if_id_stage_if.sv
// Instruction-memory fetch bus between the IF/ID stage and the instruction memory.
//   req   : fetch request valid (stage -> memory)
//   addr  : fetch address, word aligned (stage -> memory)
//   ready : rdata is valid for addr this cycle (memory -> stage)
//   rdata : fetched instruction word (memory -> stage)
interface if_id_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: owns the PC, issues instruction fetches, and holds the
// IF/ID register with a one-entry skid buffer. The skid buffer catches a word
// that returns while the hazard unit is stalling ID.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   stall, flush      : hazard-unit hold / kill the ID instruction
//   redirect_valid/pc : taken branch/jump, new fetch address
//   imem              : fetch bus (master side)
//   id_valid/pc/instr : IF/ID register contents
//   id_op..id_imm     : field slices of id_instr
//   id_ext_op         : immediate extender select (00 zero, 01 sign, 10 lui)
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  if_id_stage_if.master        imem,
  output logic                 id_valid,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_instr,
  output logic [5:0]           id_op,
  output logic [4:0]           id_rs,
  output logic [4:0]           id_rt,
  output logic [4:0]           id_rd,
  output logic [4:0]           id_shamt,
  output logic [5:0]           id_funct,
  output logic [15:0]          id_imm,
  output logic [1:0]           id_ext_op
);

  typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  // State register (with all datapath flops)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  // Next-state logic: priority redirect > flush > stall > advance
  always_comb begin
    state_d = state_q;
    if (redirect_valid || flush)
      state_d = S_FETCH;
    else if (stall) begin
      if (state_q == S_FETCH && imem.ready) state_d = S_HOLD;
    end else
      state_d = S_FETCH;
  end

  // Datapath next values, same priority order
  always_comb begin
    pc_d         = pc_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (redirect_valid) begin
      // Low bits forced so the PC can never become misaligned.
      pc_d       = {redirect_pc[31:2], 2'b00};
      id_valid_d = 1'b0;
    end else if (flush) begin
      // Any word returning this cycle is dropped; PC stays put in FETCH and,
      // in HOLD, already points past the discarded skid word.
      id_valid_d = 1'b0;
    end else if (stall) begin
      if (state_q == S_FETCH && imem.ready) begin
        skid_pc_d    = pc_q;
        skid_instr_d = imem.rdata;
        pc_d         = pc_q + 32'd4;
      end
    end else if (state_q == S_HOLD) begin
      id_valid_d = 1'b1;
      id_pc_d    = skid_pc_q;
      id_instr_d = skid_instr_q;
    end else if (imem.ready) begin
      id_valid_d = 1'b1;
      id_pc_d    = pc_q;
      id_instr_d = imem.rdata;
      pc_d       = pc_q + 32'd4;
    end else
      id_valid_d = 1'b0;
  end

  // Outputs
  always_comb begin
    imem.req  = (state_q == S_FETCH);
    imem.addr = pc_q;
    id_valid  = id_valid_q;
    id_pc     = id_pc_q;
    id_instr  = id_instr_q;
    id_op     = id_instr_q[31:26];
    id_rs     = id_instr_q[25:21];
    id_rt     = id_instr_q[20:16];
    id_rd     = id_instr_q[15:11];
    id_shamt  = id_instr_q[10:6];
    id_funct  = id_instr_q[5:0];
    id_imm    = id_instr_q[15:0];
    case (id_instr_q[31:26])
      6'h0C, 6'h0D, 6'h0E:                     id_ext_op = 2'b00;
      6'h0F:                                   id_ext_op = 2'b10;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h23, 6'h2B, 6'h04, 6'h05:              id_ext_op = 2'b01;
      default:                                 id_ext_op = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, stall = 1'b0, flush = 1'b0, redir = 1'b0, rdy = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        use_ovr = 1'b0;
  logic [31:0] ovr_word = '0;

  logic        id_valid;
  logic [31:0] id_pc, id_instr;
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [15:0] id_imm;
  logic [1:0]  id_ext_op;

  int n_cmp = 0, n_fail = 0;

  if_id_stage_if bus();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Extender select as listed in the opcode table
  function automatic logic [1:0] ref_ext(input logic [5:0] op);
    if (op == 6'h0F) return 2'b10;
    if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h04, 6'h05}) return 2'b01;
    return 2'b00;
  endfunction

  assign bus.ready = rdy;
  assign bus.rdata = use_ovr ? ovr_word : mem_word(bus.addr);

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redir), .redirect_pc(redir_pc), .imem(bus),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_funct(id_funct), .id_imm(id_imm),
    .id_ext_op(id_ext_op)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 0; flush = 0; redir = 0; rdy = 0; use_ovr = 0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1;
    tick();
    n_cmp++;
    if ({id_valid, id_pc, id_instr, id_ext_op} !== {1'b0, 32'h0, 32'h0, 2'b00}) begin
      n_fail++; $display("FAIL reset_id got v=%b pc=%h i=%h want 0/0/0", id_valid, id_pc, id_instr);
    end
    n_cmp++;
    if ({bus.req, bus.addr} !== {1'b1, 32'h0000_3000}) begin
      n_fail++; $display("FAIL reset_pc got req=%b addr=%h want 1/00003000", bus.req, bus.addr);
    end
    rst_n = 1'b1; rdy = 1'b0;
    tick();
    n_cmp++;
    if ({bus.req, bus.addr, id_valid} !== {1'b1, 32'h0000_3000, 1'b0}) begin
      n_fail++; $display("FAIL post_reset got req=%b addr=%h v=%b want 1/00003000/0", bus.req, bus.addr, id_valid);
    end
  endtask

  task automatic test_stream();
    do_reset(); rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h3000 + 32'(4*i), mem_word(32'h3000 + 32'(4*i))}) begin
        n_fail++; $display("FAIL stream[%0d] got v=%b pc=%h i=%h want pc=%h", i, id_valid, id_pc, id_instr, 32'h3000 + 32'(4*i));
      end
    end
  endtask

  task automatic test_stall_hold();
    do_reset(); rdy = 1'b1;
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({bus.req, id_valid, id_pc, bus.addr} !== {1'b0, 1'b1, 32'h3000, 32'h3008}) begin
        n_fail++; $display("FAIL hold[%0d] got req=%b v=%b pc=%h addr=%h want 0/1/3000/3008", k, bus.req, id_valid, id_pc, bus.addr);
      end
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if ({bus.req, id_valid, id_pc, id_instr, bus.addr} !== {1'b1, 1'b1, 32'h3004, mem_word(32'h3004), 32'h3008}) begin
      n_fail++; $display("FAIL unhold got req=%b v=%b pc=%h i=%h addr=%h want 1/1/3004/-/3008", bus.req, id_valid, id_pc, id_instr, bus.addr);
    end
    tick();
    n_cmp++;
    if ({id_valid, id_pc, bus.addr} !== {1'b1, 32'h3008, 32'h300C}) begin
      n_fail++; $display("FAIL after_hold got v=%b pc=%h addr=%h want 1/3008/300c", id_valid, id_pc, bus.addr);
    end
  endtask

  task automatic test_redirect_hold();
    do_reset(); rdy = 1'b1;
    tick();
    stall = 1'b1;
    tick();
    redir = 1'b1; redir_pc = 32'h0000_3100;
    tick();
    redir = 1'b0;
    n_cmp++;
    if ({id_valid, bus.req, bus.addr} !== {1'b0, 1'b1, 32'h3100}) begin
      n_fail++; $display("FAIL redirect got v=%b req=%b addr=%h want 0/1/3100", id_valid, bus.req, bus.addr);
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h3100, mem_word(32'h3100)}) begin
      n_fail++; $display("FAIL redirect_skid got v=%b pc=%h want 1/3100", id_valid, id_pc);
    end
  endtask

  task automatic test_bubbles();
    do_reset(); rdy = 1'b1;
    tick(); tick();
    rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if ({id_valid, bus.addr, id_pc} !== {1'b0, 32'h3008, 32'h3004}) begin
        n_fail++; $display("FAIL bubble[%0d] got v=%b addr=%h pc=%h want 0/3008/3004", k, id_valid, bus.addr, id_pc);
      end
    end
    rdy = 1'b1;
    tick();
    n_cmp++;
    if ({id_valid, id_pc} !== {1'b1, 32'h3008}) begin
      n_fail++; $display("FAIL after_bubble got v=%b pc=%h want 1/3008", id_valid, id_pc);
    end
  endtask

  task automatic test_decode();
    logic [31:0] w [4] = '{32'h3C01_1234, 32'h2021_FFFF, 32'h3421_8000, 32'h0022_1820};
    logic [1:0]  e [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
    logic [15:0] im [4] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h1820};
    logic [4:0]  rd [4] = '{5'd2, 5'd31, 5'd16, 5'd3};
    logic [5:0]  fn [4] = '{6'h34, 6'h3F, 6'h00, 6'h20};
    do_reset(); rdy = 1'b1; use_ovr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ovr_word = w[i];
      tick();
      n_cmp++;
      if ({id_ext_op, id_imm, id_rd, id_funct} !== {e[i], im[i], rd[i], fn[i]}) begin
        n_fail++; $display("FAIL decode[%0d] got ext=%b imm=%h rd=%0d fn=%h want ext=%b imm=%h rd=%0d fn=%h",
                           i, id_ext_op, id_imm, id_rd, id_funct, e[i], im[i], rd[i], fn[i]);
      end
    end
    for (int i = 0; i < 64; i++) begin
      ovr_word = $urandom;
      tick();
      n_cmp++;
      if ({id_op, id_rs, id_rt, id_rd, id_shamt, id_funct, id_imm, id_ext_op} !==
          {ovr_word, ovr_word[15:0], ref_ext(ovr_word[31:26])}) begin
        n_fail++; $display("FAIL decode_rand word=%h got op=%h ext=%b want ext=%b", ovr_word, id_op, id_ext_op, ref_ext(ovr_word[31:26]));
      end
    end
    use_ovr = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
    tick();
    redir = 1'b0; rdy = 1'b1;
    tick();
    n_cmp++;
    if ({bus.addr, id_pc, id_valid} !== {32'h0, 32'hFFFF_FFFC, 1'b1}) begin
      n_fail++; $display("FAIL wrap got addr=%h pc=%h v=%b want 0/fffffffc/1", bus.addr, id_pc, id_valid);
    end
  endtask

  task automatic test_flush();
    do_reset(); rdy = 1'b1;
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    n_cmp++;
    if ({id_valid, bus.addr, id_pc} !== {1'b0, 32'h3004, 32'h3000}) begin
      n_fail++; $display("FAIL flush_fetch got v=%b addr=%h pc=%h want 0/3004/3000", id_valid, bus.addr, id_pc);
    end
    tick();
    stall = 1'b1; tick();
    flush = 1'b1; tick(); flush = 1'b0;
    n_cmp++;
    if ({bus.req, id_valid, bus.addr} !== {1'b1, 1'b0, 32'h300C}) begin
      n_fail++; $display("FAIL flush_hold got req=%b v=%b addr=%h want 1/0/300c", bus.req, id_valid, bus.addr);
    end
    stall = 1'b0; tick();
    n_cmp++;
    if ({id_valid, id_pc} !== {1'b1, 32'h300C}) begin
      n_fail++; $display("FAIL flush_hold_next got v=%b pc=%h want 1/300c", id_valid, id_pc);
    end
    stall = 1'b1; tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1; stall = 1'b0;
    n_cmp++;
    if ({id_valid, bus.req, bus.addr, id_pc} !== {1'b0, 1'b1, 32'h3000, 32'h0}) begin
      n_fail++; $display("FAIL reset_hold got v=%b req=%b addr=%h pc=%h want 0/1/3000/0", id_valid, bus.req, bus.addr, id_pc);
    end
    tick();
    n_cmp++;
    if ({id_valid, id_pc} !== {1'b1, 32'h3000}) begin
      n_fail++; $display("FAIL reset_hold_next got v=%b pc=%h want 1/3000", id_valid, id_pc);
    end
  endtask

  // Random traffic against a cycle reference built from the per-cycle rules
  task automatic test_random();
    logic [31:0] m_pc = 32'h3000, m_id_pc = '0, m_id_i = '0, s_pc = '0, s_i = '0;
    logic        m_v = 1'b0, m_hold = 1'b0;
    int          fails0 = n_fail;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      redir = ($urandom_range(0, 19) == 0);
      flush = ($urandom_range(0, 14) == 0);
      stall = ($urandom_range(0, 9) < 3);
      rdy   = ($urandom_range(0, 9) < 7);
      redir_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)
                                             : 32'h3000 + 32'($urandom_range(0, 255) * 4);
      #1;
      n_cmp++;
      if ({bus.req, bus.addr} !== {~m_hold, m_pc}) begin
        n_fail++; $display("FAIL rand_fetch c=%0d got req=%b addr=%h want %b/%h", c, bus.req, bus.addr, ~m_hold, m_pc);
      end
      if (!rst_n) begin
        m_pc = 32'h3000; m_hold = 0; m_v = 0; m_id_pc = 0; m_id_i = 0;
      end else if (redir) begin
        m_pc = redir_pc; m_hold = 0; m_v = 0;
      end else if (flush) begin
        m_v = 0; m_hold = 0;
      end else if (stall) begin
        if (!m_hold && rdy) begin s_pc = m_pc; s_i = mem_word(m_pc); m_pc += 4; m_hold = 1; end
      end else if (m_hold) begin
        m_id_pc = s_pc; m_id_i = s_i; m_v = 1; m_hold = 0;
      end else if (rdy) begin
        m_id_pc = m_pc; m_id_i = mem_word(m_pc); m_v = 1; m_pc += 4;
      end else
        m_v = 0;
      @(posedge clk); #1;
      n_cmp++;
      if ({id_valid, id_pc, id_instr, id_ext_op} !== {m_v, m_id_pc, m_id_i, ref_ext(m_id_i[31:26])}) begin
        n_fail++; $display("FAIL rand_id c=%0d got v=%b pc=%h i=%h want v=%b pc=%h i=%h", c, id_valid, id_pc, id_instr, m_v, m_id_pc, m_id_i);
      end
      if (n_fail - fails0 > 20) break;
    end
    rst_n = 1'b1; redir = 0; flush = 0; stall = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect_hold();
    test_bubbles();
    test_decode();
    test_wrap();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
